// File: rtl/ldpc_err_stat.sv
`default_nettype none
// ============================================================================
//  Module   : ldpc_err_stat
//  Purpose  : BER statistics stage - chunk-serial bit-error popcount of each
//             decoded frame against the all-zero codeword, with saturating
//             frame / frame-error / bit-error / undetected-error counters and
//             frame-budget / frame-error-budget stop control.
//  Revision : 1.0 - initial release
// ============================================================================
module ldpc_err_stat #(
    parameter int DIM   = 2304,
    parameter int CHUNK = 96,
    parameter int CNT_W = 32,
    parameter int FRM_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [FRM_W-1:0] max_frames,
    input  logic [FRM_W-1:0] max_ferr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DIM-1:0]   in_res,
    input  logic             in_ferr,
    output logic [FRM_W-1:0] frames,
    output logic [FRM_W-1:0] frame_errs,
    output logic [CNT_W-1:0] bit_errs,
    output logic [FRM_W-1:0] undet_errs,
    output logic             busy,
    output logic             done
);

    localparam int c_NCH    = DIM / CHUNK;
    localparam int c_PART_W = $clog2(DIM + 1);
    localparam int c_POP_W  = $clog2(CHUNK + 1);
    localparam int c_IDX_W  = (c_NCH > 1) ? $clog2(c_NCH) : 1;
    localparam int c_SUM_W  = ((CNT_W > c_PART_W) ? CNT_W : c_PART_W) + 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_NCH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARMED  = 3'd1,
        S_COUNT  = 3'd2,
        S_UPDATE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_nx;
    logic [DIM-1:0]       r_shadow;
    logic                 r_ferr;
    logic [c_PART_W-1:0]  r_partial;
    logic [c_IDX_W-1:0]   r_idx;
    logic [FRM_W-1:0]     r_frames;
    logic [FRM_W-1:0]     r_frame_errs;
    logic [CNT_W-1:0]     r_bit_errs;
    logic [FRM_W-1:0]     r_undet_errs;

    logic [c_POP_W-1:0]   w_pop;
    logic [c_SUM_W-1:0]   w_bit_sum;
    logic [CNT_W-1:0]     w_bit_nx;
    logic [FRM_W-1:0]     w_frames_nx;
    logic [FRM_W-1:0]     w_ferr_nx;
    logic [FRM_W-1:0]     w_undet_nx;
    logic                 w_stop;

    // The shadow shifts right each COUNT cycle, so the low CHUNK bits are
    // always the chunk selected by the current index.
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < CHUNK; i++) begin
            w_pop = w_pop + c_POP_W'(r_shadow[i]);
        end
    end

    always_comb begin
        w_bit_sum   = c_SUM_W'(r_bit_errs) + c_SUM_W'(r_partial);
        w_bit_nx    = (|w_bit_sum[c_SUM_W-1:CNT_W]) ? '1 : w_bit_sum[CNT_W-1:0];
        w_frames_nx = (&r_frames) ? r_frames : r_frames + FRM_W'(1);
        w_ferr_nx   = (r_ferr && !(&r_frame_errs)) ? r_frame_errs + FRM_W'(1)
                                                    : r_frame_errs;
        w_undet_nx  = (!r_ferr && (r_partial != '0) && !(&r_undet_errs))
                      ? r_undet_errs + FRM_W'(1) : r_undet_errs;
        w_stop      = ((max_frames != '0) && (w_frames_nx >= max_frames)) ||
                      ((max_ferr != '0) && (w_ferr_nx >= max_ferr));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        if (start) begin
            w_state_nx = S_ARMED;
        end else begin
            case (r_state)
                S_ARMED:  if (in_valid) w_state_nx = S_COUNT;
                S_COUNT:  if (r_idx == c_LAST_IDX) w_state_nx = S_UPDATE;
                S_UPDATE: w_state_nx = w_stop ? S_DONE : S_ARMED;
                default:  w_state_nx = r_state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow     <= '0;
            r_ferr       <= 1'b0;
            r_partial    <= '0;
            r_idx        <= '0;
            r_frames     <= '0;
            r_frame_errs <= '0;
            r_bit_errs   <= '0;
            r_undet_errs <= '0;
        end else if (start) begin
            r_partial    <= '0;
            r_idx        <= '0;
            r_frames     <= '0;
            r_frame_errs <= '0;
            r_bit_errs   <= '0;
            r_undet_errs <= '0;
        end else begin
            case (r_state)
                S_ARMED: begin
                    if (in_valid) begin
                        r_shadow  <= in_res;
                        r_ferr    <= in_ferr;
                        r_partial <= '0;
                        r_idx     <= '0;
                    end
                end
                S_COUNT: begin
                    r_partial <= r_partial + c_PART_W'(w_pop);
                    r_shadow  <= r_shadow >> CHUNK;
                    r_idx     <= r_idx + c_IDX_W'(1);
                end
                S_UPDATE: begin
                    r_frames     <= w_frames_nx;
                    r_frame_errs <= w_ferr_nx;
                    r_bit_errs   <= w_bit_nx;
                    r_undet_errs <= w_undet_nx;
                end
                default: ;
            endcase
        end
    end

    assign in_ready   = (r_state == S_ARMED);
    assign busy       = (r_state == S_ARMED) || (r_state == S_COUNT) ||
                        (r_state == S_UPDATE);
    assign done       = (r_state == S_DONE);
    assign frames     = r_frames;
    assign frame_errs = r_frame_errs;
    assign bit_errs   = r_bit_errs;
    assign undet_errs = r_undet_errs;

endmodule
`default_nettype wire

// File: tb/tb_ldpc_err_stat.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ldpc_err_stat
//  Purpose  : Directed bench for ldpc_err_stat with a transaction-level model
//             compared every cycle, plus hand-computed literal checkpoints.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ldpc_err_stat;

    localparam int DIM   = 2304;
    localparam int CHUNK = 96;
    localparam int NCH   = DIM / CHUNK;
    localparam int FRM_W = 24;
    localparam longint FRM_MAX = (64'd1 << 24) - 1;
    localparam longint B32_MAX = (64'd1 << 32) - 1;
    localparam longint B12_MAX = (64'd1 << 12) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [FRM_W-1:0] max_frames = '0;
    logic [FRM_W-1:0] max_ferr = '0;
    logic             in_valid = 1'b0;
    logic [DIM-1:0]   in_res = '0;
    logic             in_ferr = 1'b0;

    logic             in_ready, busy, done;
    logic [FRM_W-1:0] frames, frame_errs, undet_errs;
    logic [31:0]      bit_errs;
    logic             in_ready12, busy12, done12;
    logic [FRM_W-1:0] frames12, frame_errs12, undet_errs12;
    logic [11:0]      bit_errs12;

    ldpc_err_stat #(.DIM(DIM), .CHUNK(CHUNK), .CNT_W(32), .FRM_W(FRM_W)) dut (
        .clk(clk), .rst(rst), .start(start), .max_frames(max_frames),
        .max_ferr(max_ferr), .in_valid(in_valid), .in_ready(in_ready),
        .in_res(in_res), .in_ferr(in_ferr), .frames(frames),
        .frame_errs(frame_errs), .bit_errs(bit_errs), .undet_errs(undet_errs),
        .busy(busy), .done(done)
    );

    ldpc_err_stat #(.DIM(DIM), .CHUNK(CHUNK), .CNT_W(12), .FRM_W(FRM_W)) dut12 (
        .clk(clk), .rst(rst), .start(start), .max_frames(max_frames),
        .max_ferr(max_ferr), .in_valid(in_valid), .in_ready(in_ready12),
        .in_res(in_res), .in_ferr(in_ferr), .frames(frames12),
        .frame_errs(frame_errs12), .bit_errs(bit_errs12),
        .undet_errs(undet_errs12), .busy(busy12), .done(done12)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: 0 idle, 1 armed, 2 frame in flight, 3 done.
    int     m_mode = 0;
    int     m_left = 0;
    longint m_pop = 0;
    bit     m_ferr = 1'b0;
    longint m_frames = 0, m_ferrs = 0, m_bits = 0, m_bits12 = 0, m_undet = 0;

    always @(posedge clk) begin : model
        longint nf, ne;
        nf = (m_frames == FRM_MAX) ? m_frames : m_frames + 1;
        ne = (m_ferr && m_ferrs != FRM_MAX) ? m_ferrs + 1 : m_ferrs;
        if (rst) begin
            m_mode <= 0; m_frames <= 0; m_ferrs <= 0; m_bits <= 0;
            m_bits12 <= 0; m_undet <= 0; m_left <= 0;
        end else if (start) begin
            m_mode <= 1; m_frames <= 0; m_ferrs <= 0; m_bits <= 0;
            m_bits12 <= 0; m_undet <= 0;
        end else if (m_mode == 1 && in_valid) begin
            m_pop  <= longint'($countones(in_res));
            m_ferr <= in_ferr;
            m_left <= NCH + 1;
            m_mode <= 2;
        end else if (m_mode == 2) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_frames <= nf;
                m_ferrs  <= ne;
                m_bits   <= (m_bits + m_pop > B32_MAX) ? B32_MAX : m_bits + m_pop;
                m_bits12 <= (m_bits12 + m_pop > B12_MAX) ? B12_MAX : m_bits12 + m_pop;
                if (!m_ferr && m_pop != 0) m_undet <= m_undet + 1;
                m_mode <= (((max_frames != 0) && (nf >= max_frames)) ||
                           ((max_ferr != 0) && (ne >= max_ferr))) ? 3 : 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready",   in_ready,   m_mode == 1);
            check("busy",       busy,       m_mode == 1 || m_mode == 2);
            check("done",       done,       m_mode == 3);
            check("frames",     frames,     m_frames);
            check("frame_errs", frame_errs, m_ferrs);
            check("bit_errs",   bit_errs,   m_bits);
            check("undet_errs", undet_errs, m_undet);
            check("bit_errs12", bit_errs12, m_bits12);
            check("frames12",   frames12,   m_frames);
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [DIM-1:0] res, input bit ferr);
        bit ok;
        ok = 1'b0;
        in_res = res; in_ferr = ferr; in_valid = 1'b1;
        for (int n = 0; n < 200 && !ok; n++) begin
            if (in_ready) ok = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0; in_res = '0; in_ferr = 1'b0;
        if (!ok) check("accept_timeout", 0, 1);
    endtask

    task automatic wait_done(output int k);
        k = 0;
        for (int n = 1; n <= 200 && k == 0; n++) begin
            @(negedge clk);
            if (done) k = n;
        end
        if (k == 0) check("done_timeout", 0, 1);
    endtask

    logic [DIM-1:0] pat;
    int lat;

    initial begin
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("rst_frames", frames, 0);
        check("rst_ready", in_ready, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
        @(negedge clk);

        // Three clean frames against a 3-frame budget
        max_frames = 3; max_ferr = 0;
        pulse_start();
        check("armed_after_start", in_ready, 1);
        repeat (3) send('0, 1'b0);
        wait_done(lat);
        check("done_latency", lat, NCH + 1);
        check("t1_frames", frames, 3);
        check("t1_bits", bit_errs, 0);

        // Chunk-boundary bits
        max_frames = 1;
        pulse_start();
        pat = '0; pat[0] = 1'b1; pat[95] = 1'b1; pat[96] = 1'b1; pat[2303] = 1'b1;
        send(pat, 1'b1);
        wait_done(lat);
        check("t2_bits", bit_errs, 4);
        check("t2_ferr", frame_errs, 1);
        check("t2_undet", undet_errs, 0);

        // All-ones, undetected
        pulse_start();
        send('1, 1'b0);
        wait_done(lat);
        check("t3_bits", bit_errs, 2304);
        check("t3_undet", undet_errs, 1);

        // Saturation of the 12-bit counter
        max_frames = 3;
        pulse_start();
        send('1, 1'b0);
        send('1, 1'b0);
        repeat (NCH + 1) @(negedge clk);
        check("t4_sat12_2nd", bit_errs12, 4095);
        send('1, 1'b0);
        wait_done(lat);
        check("t4_sat12_3rd", bit_errs12, 4095);
        check("t4_bits32", bit_errs, 6912);

        // Frame-error budget; 4th frame refused
        max_frames = 0; max_ferr = 2;
        pulse_start();
        send('0, 1'b1);
        send('0, 1'b0);
        send('0, 1'b1);
        wait_done(lat);
        in_valid = 1'b1; in_ferr = 1'b1;
        repeat (30) @(negedge clk);
        in_valid = 1'b0; in_ferr = 1'b0;
        check("t5_frames", frames, 3);
        check("t5_ferr", frame_errs, 2);
        check("t5_ready", in_ready, 0);

        // Abort on the 10th COUNT cycle
        max_ferr = 0;
        pulse_start();
        pat = '0;
        for (int i = 0; i < 50; i++) pat[i] = 1'b1;
        send(pat, 1'b0);
        repeat (9) @(negedge clk);
        pulse_start();
        check("t6_frames", frames, 0);
        check("t6_bits", bit_errs, 0);
        check("t6_armed", in_ready, 1);
        send('0, 1'b0);
        repeat (NCH + 2) @(negedge clk);
        check("t6_frames_after", frames, 1);
        check("t6_bits_after", bit_errs, 0);

        // start coinciding with in_valid in ARMED: frame refused
        in_valid = 1'b1; in_res = '1;
        pulse_start();
        in_valid = 1'b0; in_res = '0;
        repeat (NCH + 4) @(negedge clk);
        check("t7_frames", frames, 0);
        check("t7_ready", in_ready, 1);

        // rst mid-frame
        send('1, 1'b1);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t8_busy", busy, 0);
        check("t8_ready", in_ready, 0);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
